prog_divider: RTL and testbench

//   Runtime-programmable successor of the fixed-constant split/divider block. Divides clk by a

---
 rtl/prog_divider.sv | 72 +++++++
 tb/tb_prog_divider.sv | 96 +++++++++
 2 files changed

// File: rtl/prog_divider.sv
// prog_divider: loadable clock divider with toggle, pulse, PWM and one-shot output modes
module prog_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [1:0]       mode_in,
    output logic             out,
    output logic             tick,
    output logic [WIDTH-1:0] out_counter
);
    typedef enum logic [1:0] {TOGGLE, PULSE, PWM, ONESHOT} mode_t;
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_DUTY = WIDTH'(DEFAULT_DIV / 2);
    logic [WIDTH-1:0] div_q, div_d, duty_q, duty_d, cnt_q, cnt_d, last;
    mode_t            mode_q, mode_d;
    logic             out_q, out_d, tick_q, tick_d, done_q, done_d, wrap;
    always_comb begin
        last   = (div_q == '0) ? '0 : div_q - WIDTH'(1);
        wrap   = cnt_q == last;
        div_d  = div_q;
        duty_d = duty_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        done_d = done_q;
        // pulse output mirrors tick, so it drops whenever no wrap occurs
        out_d  = (mode_q == PULSE) ? 1'b0 : out_q;
        if (load) begin
            div_d  = div_in;
            duty_d = duty_in;
            mode_d = mode_t'(mode_in);
            cnt_d  = '0;
            out_d  = 1'b0;
            done_d = 1'b0;
        end else if (en && !done_q) begin
            cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
            tick_d = wrap;
            done_d = (mode_q == ONESHOT) && wrap;
            out_d  = (mode_q == TOGGLE) ? out_q ^ wrap :
                     (mode_q == PULSE)  ? wrap :
                     (mode_q == PWM)    ? (cnt_d < duty_q) : (out_q | wrap);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DEF_DIV;
            duty_q <= DEF_DUTY;
            mode_q <= TOGGLE;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            duty_q <= duty_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end
    assign out         = out_q;
    assign tick        = tick_q;
    assign out_counter = cnt_q;
endmodule

// File: tb/tb_prog_divider.sv
// tb_prog_divider: directed and random stimulus against a phase-counting reference model
module tb_prog_divider;
    logic       clk, rst, en, load;
    logic [7:0] div_in, duty_in, out_counter;
    logic [1:0] mode_in;
    logic       out, tick;
    int passed = 0, total = 0;
    int m_div, m_duty, m_mode, phase;
    bit stepped;

    prog_divider #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in), .duty_in(duty_in),
        .mode_in(mode_in), .out(out), .tick(tick), .out_counter(out_counter)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: phase counts enabled cycles since the last load/reset; everything else follows from it.
    task automatic step(input bit r, input bit l, input bit e, input int d, input int du, input int m);
        int pe, ecnt, etick, eout;
        rst = r; load = l; en = e; div_in = d[7:0]; duty_in = du[7:0]; mode_in = m[1:0];
        @(posedge clk);
        if (r) begin
            m_div = 10; m_duty = 5; m_mode = 0; phase = 0; stepped = 0;
        end else if (l) begin
            m_div = d & 255; m_duty = du & 255; m_mode = m & 3; phase = 0; stepped = 0;
        end else if (e) begin
            phase++; stepped = 1;
        end else stepped = 0;
        #1;
        pe = (m_div == 0) ? 1 : m_div;
        ecnt = (m_mode == 3 && phase >= pe) ? 0 : phase % pe;
        etick = (stepped && phase > 0 && phase % pe == 0 && !(m_mode == 3 && phase > pe)) ? 1 : 0;
        case (m_mode)
            0: eout = (phase / pe) % 2;
            1: eout = etick;
            2: eout = (phase == 0) ? 0 : ((ecnt < m_duty) ? 1 : 0);
            default: eout = (phase >= pe) ? 1 : 0;
        endcase
        check("out_counter", int'(out_counter), ecnt);
        check("tick", int'(tick), etick);
        check("out", int'(out), eout);
    endtask

    initial begin
        rst = 1; load = 0; en = 0; div_in = 0; duty_in = 0; mode_in = 0;
        m_div = 10; m_duty = 5; m_mode = 0; phase = 0; stepped = 0;
        // default toggle operation
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 45; i++) step(0, 0, 1, 0, 0, 0);
        // PWM 1-of-4
        step(0, 1, 1, 4, 1, 2);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0);
        // PWM duty extremes
        step(0, 1, 0, 6, 0, 2);
        for (int i = 0; i < 13; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 6, 9, 2);
        for (int i = 0; i < 13; i++) step(0, 0, 1, 0, 0, 0);
        // period 0 and 1 in pulse mode
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
        // one-shot and restart
        step(0, 1, 0, 5, 0, 3);
        for (int i = 0; i < 25; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 5, 0, 3);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
        // hold with en=0, then reset mid-count
        step(0, 1, 0, 10, 5, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0);
        // random mix of loads, enables and occasional resets
        for (int i = 0; i < 600; i++) begin
            automatic int r = ($urandom_range(0, 99) == 0) ? 1 : 0;
            automatic int l = ($urandom_range(0, 29) == 0) ? 1 : 0;
            step(r[0], l[0], $urandom_range(0, 3) != 0, $urandom_range(0, 12),
                 $urandom_range(0, 14), $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
